// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the MIPS datapath and its hazard/forwarding
// controller. The datapath is the master: it supplies register numbers and
// control bits, and it receives forwarding selects, stalls and flushes back.
interface pipeline_hazard_ctrl_if #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
);
  localparam int MCW = $clog2(MC_LAT);

  // Datapath -> controller
  logic [AW-1:0]    rsD, rtD, rsE, rtE;
  logic [AW-1:0]    WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD;
  logic             McOpE;
  logic             PerfClr;

  // Controller -> datapath
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             StallF, StallD, StallE;
  logic             FlushE, FlushM;
  logic [MCW-1:0]   McCnt;
  logic             McDone;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, McOpE, PerfClr,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, FlushE, FlushM, McCnt, McDone, StallCnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, McOpE, PerfClr,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, FlushE, FlushM, McCnt, McDone, StallCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Forwarding selects for E and D, load-use and branch-in-D stalls, a
// multi-cycle execute occupancy counter that freezes F/D/E while bubbling M,
// and a saturating counter of stalled fetch cycles.
module pipeline_hazard_ctrl #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clka,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int             MCW      = $clog2(MC_LAT);
  localparam logic [MCW-1:0] MC_LAST  = MCW'(MC_LAT - 1);
  localparam logic [AW-1:0]  REG_ZERO = '0;

  logic [MCW-1:0]   mc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lwstall, brstall, mcstall, mc_last, stall_any;
  logic [1:0]       fwd_ae, fwd_be;

  // E-stage forwarding: the younger M result wins over W; $0 never forwards.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_ae = 2'b00;
    fwd_be = 2'b00;
    if (hz.rsE != REG_ZERO && hz.RegWriteM && hz.rsE == hz.WriteRegM)
      fwd_ae = 2'b10;
    else if (hz.rsE != REG_ZERO && hz.RegWriteW && hz.rsE == hz.WriteRegW)
      fwd_ae = 2'b01;
    if (hz.rtE != REG_ZERO && hz.RegWriteM && hz.rtE == hz.WriteRegM)
      fwd_be = 2'b10;
    else if (hz.rtE != REG_ZERO && hz.RegWriteW && hz.rtE == hz.WriteRegW)
      fwd_be = 2'b01;
  end

  assign hz.ForwardAE = fwd_ae;
  assign hz.ForwardBE = fwd_be;
  assign hz.ForwardAD = (hz.rsD != REG_ZERO) && hz.RegWriteM && (hz.rsD == hz.WriteRegM);
  assign hz.ForwardBD = (hz.rtD != REG_ZERO) && hz.RegWriteM && (hz.rtD == hz.WriteRegM);

  // A load in E feeding D, or a branch in D whose operand is still being
  // produced in E (any write) or loaded in M, must wait a cycle.
  assign lwstall = hz.MemtoRegE && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
  assign brstall = hz.BranchD &&
                   ((hz.RegWriteE && (hz.WriteRegE == hz.rsD || hz.WriteRegE == hz.rtD)) ||
                    (hz.MemtoRegM && (hz.WriteRegM == hz.rsD || hz.WriteRegM == hz.rtD)));

  // The multi-cycle op holds E until its final (McDone) cycle.
  assign mc_last   = (mc_cnt == MC_LAST);
  assign mcstall   = hz.McOpE && !mc_last;
  assign stall_any = lwstall || brstall || mcstall;

  assign hz.StallF   = stall_any;
  assign hz.StallD   = stall_any;
  assign hz.StallE   = mcstall;
  assign hz.FlushM   = mcstall;
  // E must never be cleared while it is holding a multi-cycle op.
  assign hz.FlushE   = (lwstall || brstall) && !mcstall;
  assign hz.McDone   = hz.McOpE && mc_last;
  assign hz.McCnt    = mc_cnt;
  assign hz.StallCnt = stall_cnt;

  // Occupancy counter: counts 0..MC_LAT-1 while McOpE is high, wraps so
  // back-to-back ops each take MC_LAT cycles, and restarts whenever E drops
  // the op (abort or flush).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                 mc_cnt <= '0;
    else if (!hz.McOpE)       mc_cnt <= '0;
    else if (mc_last)         mc_cnt <= '0;
    else                      mc_cnt <= mc_cnt + 1'b1;
  end

  // Stalled-fetch performance counter; clear wins, saturates at all-ones.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                              stall_cnt <= '0;
    else if (hz.PerfClr)                   stall_cnt <= '0;
    else if (stall_any && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. A behavioural model derived from
// the pipeline rules is compared against every output on each falling edge,
// and hand-computed literals pin the model at the interesting points.
module tb_pipeline_hazard_ctrl;
  localparam int AW     = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clka = 1'b0;
  logic rst  = 1'b0;
  int   vectors = 0;
  int   fails   = 0;
  bit   cmp_on  = 1'b0;

  // Model state
  int m_mc    = 0;
  int m_stall = 0;

  pipeline_hazard_ctrl_if #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clka (clka),
    .rst  (rst),
    .hz   (hz.slave)
  );

  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Forwarding source for one operand: 2 = M, 1 = W, 0 = regfile.
  function automatic int fwd_src(int src, int m_dst, bit m_we, int w_dst, bit w_we);
    if (src == 0) return 0;
    if (m_we && src == m_dst) return 2;
    if (w_we && src == w_dst) return 1;
    return 0;
  endfunction

  function automatic bit reads(int dst, int a, int b);
    return (dst == a) || (dst == b);
  endfunction

  function automatic bit m_lw();
    return hz.MemtoRegE && reads(int'(hz.rtE), int'(hz.rsD), int'(hz.rtD));
  endfunction

  function automatic bit m_br();
    return hz.BranchD &&
           ((hz.RegWriteE && reads(int'(hz.WriteRegE), int'(hz.rsD), int'(hz.rtD))) ||
            (hz.MemtoRegM && reads(int'(hz.WriteRegM), int'(hz.rsD), int'(hz.rtD))));
  endfunction

  function automatic bit m_mcs();
    return hz.McOpE && (m_mc != MC_LAT - 1);
  endfunction

  // Model register updates.
  always @(posedge clka or negedge rst) begin
    if (!rst) begin
      m_mc    = 0;
      m_stall = 0;
    end else begin
      bit st;
      st = m_lw() || m_br() || m_mcs();
      if (hz.PerfClr) m_stall = 0;
      else if (st && m_stall < SAT) m_stall = m_stall + 1;
      m_mc = hz.McOpE ? (m_mc + 1) % MC_LAT : 0;
    end
  end

  // Full-output compare on every falling edge.
  always @(negedge clka) begin
    if (cmp_on) begin
      bit lw, br, mc, st;
      lw = m_lw(); br = m_br(); mc = m_mcs(); st = lw || br || mc;
      check("cyc ForwardAE", hz.ForwardAE,
            fwd_src(int'(hz.rsE), int'(hz.WriteRegM), hz.RegWriteM, int'(hz.WriteRegW), hz.RegWriteW));
      check("cyc ForwardBE", hz.ForwardBE,
            fwd_src(int'(hz.rtE), int'(hz.WriteRegM), hz.RegWriteM, int'(hz.WriteRegW), hz.RegWriteW));
      check("cyc ForwardAD", hz.ForwardAD,
            fwd_src(int'(hz.rsD), int'(hz.WriteRegM), hz.RegWriteM, 0, 1'b0) == 2);
      check("cyc ForwardBD", hz.ForwardBD,
            fwd_src(int'(hz.rtD), int'(hz.WriteRegM), hz.RegWriteM, 0, 1'b0) == 2);
      check("cyc StallF", hz.StallF, st);
      check("cyc StallD", hz.StallD, st);
      check("cyc StallE", hz.StallE, mc);
      check("cyc FlushM", hz.FlushM, mc);
      check("cyc FlushE", hz.FlushE, (lw || br) && !mc);
      check("cyc McDone", hz.McDone, hz.McOpE && m_mc == MC_LAT - 1);
      check("cyc McCnt", hz.McCnt, m_mc);
      check("cyc StallCnt", hz.StallCnt, m_stall);
    end
  end

  task automatic idle();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
    hz.BranchD = 1'b0; hz.McOpE = 1'b0; hz.PerfClr = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    #13;
    check("reset McCnt", hz.McCnt, 0);
    check("reset StallCnt", hz.StallCnt, 0);
    check("reset StallF", hz.StallF, 0);
    cmp_on = 1'b1;
    @(negedge clka);
    rst = 1'b1;
    cyc();

    // Forwarding priority
    hz.rsE = 5'd3; hz.WriteRegM = 5'd3; hz.RegWriteM = 1'b1;
    hz.WriteRegW = 5'd3; hz.RegWriteW = 1'b1; hz.rtE = 5'd3;
    @(negedge clka);
    check("fwd AE M wins", hz.ForwardAE, 2'b10);
    check("fwd BE M wins", hz.ForwardBE, 2'b10);
    cyc();
    hz.RegWriteM = 1'b0;
    @(negedge clka);
    check("fwd AE W", hz.ForwardAE, 2'b01);
    cyc();
    hz.rsE = 5'd0;
    @(negedge clka);
    check("fwd AE zero reg", hz.ForwardAE, 2'b00);
    check("fwd BE W", hz.ForwardBE, 2'b01);
    cyc();
    idle();
    hz.rsD = 5'd4; hz.WriteRegM = 5'd4; hz.RegWriteM = 1'b1;
    @(negedge clka);
    check("fwd AD", hz.ForwardAD, 1);
    check("fwd BD idle", hz.ForwardBD, 0);
    cyc();

    // Load-use
    idle();
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8;
    @(negedge clka);
    check("lw StallF", hz.StallF, 1);
    check("lw FlushE", hz.FlushE, 1);
    check("lw StallE", hz.StallE, 0);
    check("lw FlushM", hz.FlushM, 0);
    cyc();
    hz.rtE = 5'd9;
    @(negedge clka);
    check("lw clear StallD", hz.StallD, 0);
    check("lw clear FlushE", hz.FlushE, 0);
    cyc();

    // Branch in D waiting on an ALU result in E, then forwarded from M
    idle();
    hz.BranchD = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd5; hz.rtD = 5'd5;
    @(negedge clka);
    check("br StallD", hz.StallD, 1);
    check("br FlushE", hz.FlushE, 1);
    cyc();
    hz.RegWriteE = 1'b0; hz.WriteRegE = 5'd0;
    hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd5;
    @(negedge clka);
    check("br ForwardBD", hz.ForwardBD, 1);
    check("br StallD off", hz.StallD, 0);
    cyc();

    // Multi-cycle op, single then back-to-back
    idle();
    cyc();
    for (int i = 0; i < MC_LAT; i++) begin
      hz.McOpE = 1'b1;
      @(negedge clka);
      check("mc McCnt", hz.McCnt, i);
      check("mc StallE", hz.StallE, (i < 3) ? 1 : 0);
      check("mc FlushM", hz.FlushM, (i < 3) ? 1 : 0);
      check("mc McDone", hz.McDone, (i == 3) ? 1 : 0);
      cyc();
    end
    idle();
    cyc();
    for (int i = 0; i < 2 * MC_LAT; i++) begin
      hz.McOpE = 1'b1;
      @(negedge clka);
      check("mc2 McCnt", hz.McCnt, i % 4);
      check("mc2 McDone", hz.McDone, (i % 4 == 3) ? 1 : 0);
      cyc();
    end

    // Multi-cycle op together with a load-use: FlushE suppressed
    idle();
    cyc();
    hz.McOpE = 1'b1; hz.MemtoRegE = 1'b1; hz.rtE = 5'd7; hz.rtD = 5'd7;
    @(negedge clka);
    check("mc+lw FlushE", hz.FlushE, 0);
    check("mc+lw StallF", hz.StallF, 1);
    cyc();

    // Reset mid-op
    idle();
    cyc();
    hz.McOpE = 1'b1;
    cyc();
    cyc();
    check("pre-reset McCnt", hz.McCnt, 2);
    #2;
    rst = 1'b0;
    #1;
    check("async McCnt", hz.McCnt, 0);
    check("async StallCnt", hz.StallCnt, 0);
    @(negedge clka);
    #1;
    rst = 1'b1;
    #1;
    check("release McCnt", hz.McCnt, 0);
    cyc();
    @(negedge clka);
    check("restart McCnt", hz.McCnt, 1);
    hz.McOpE = 1'b0;
    cyc();
    check("abort McCnt", hz.McCnt, 0);

    // Perf counter saturation and clear
    idle();
    hz.PerfClr = 1'b1;
    cyc();
    check("perf clr", hz.StallCnt, 0);
    hz.PerfClr = 1'b0;
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("perf count", hz.StallCnt, (k > SAT) ? SAT : k);
    end
    hz.PerfClr = 1'b1;
    cyc();
    check("perf clr prio", hz.StallCnt, 0);
    hz.PerfClr = 1'b0;
    cyc();
    check("perf restart", hz.StallCnt, 1);

    idle();
    cyc();
    @(negedge clka);
    #1;
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
